// File: rtl/tbu_param.sv
// rtl/tbu_param.sv - parametrised Viterbi traceback unit with LIFO output reversal
//
// Walks the survivor RAM backwards from (StartPage, StartState), one trellis
// step per READ/CAPTURE pair. The first TB_DEPTH steps only converge the path;
// the next DEC_LEN decision bits are pushed into a LIFO and then streamed out
// oldest-first over a valid/ready handshake.
//
// Ports:
//   Clock, Reset        single clock, synchronous active-high reset
//   Start               begin a traceback (sampled only while idle)
//   StartPage           page of the newest trellis step, captured with Start
//   StartState          initial trellis state, captured with Start
//   RamRd, RamAddr      survivor RAM read strobe and {page, state upper bits}
//   RamData             survivor word, valid the cycle after RamRd
//   DataOut, DataValid  decoded bit stream towards the sink
//   DataReady           sink accepts the current bit
//   DataLast            marks the final bit of the block
//   Busy                high while a traceback or drain is in progress
//   Done                one-cycle pulse after the last bit is accepted

module tbu_param #(
  parameter int WD_STATE = 8,
  parameter int WD_WORD  = 8,
  parameter int WD_PAGE  = 6,
  parameter int TB_DEPTH = 63,
  parameter int DEC_LEN  = 16,
  localparam int WD_SEL  = $clog2(WD_WORD),
  localparam int WD_ADDR = WD_PAGE + WD_STATE - WD_SEL
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic [WD_PAGE-1:0]  StartPage,
  input  logic [WD_STATE-1:0] StartState,
  output logic                RamRd,
  output logic [WD_ADDR-1:0]  RamAddr,
  input  logic [WD_WORD-1:0]  RamData,
  output logic                DataOut,
  output logic                DataValid,
  input  logic                DataReady,
  output logic                DataLast,
  output logic                Busy,
  output logic                Done
);

  localparam int N_STEPS = TB_DEPTH + DEC_LEN;
  localparam int WD_STEP = $clog2(N_STEPS + 1);
  localparam int WD_CNT  = $clog2(DEC_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  state_t              r_state;
  logic [WD_STATE-1:0] r_cur;
  logic [WD_PAGE-1:0]  r_page;
  logic [WD_STEP-1:0]  r_step;
  logic [DEC_LEN-1:0]  r_lifo;
  logic [WD_CNT-1:0]   r_cnt;
  logic                r_ram_rd;
  logic [WD_ADDR-1:0]  r_ram_addr;
  logic                r_valid;
  logic                r_done;

  logic                w_bit;
  logic [WD_STATE-1:0] w_nxt;
  logic [WD_PAGE-1:0]  w_page_dec;
  logic                w_keep;
  logic                w_last_step;

  // Survivor decision for the current state, shifted in as the new LSB:
  // walking backwards, the predecessor's MSB is the bit decoded at this step.
  assign w_bit       = RamData[r_cur[WD_SEL-1:0]];
  assign w_nxt       = {r_cur[WD_STATE-2:0], w_bit};
  assign w_page_dec  = r_page - WD_PAGE'(1);
  assign w_keep      = (r_step >= WD_STEP'(TB_DEPTH));
  assign w_last_step = (r_step == WD_STEP'(N_STEPS - 1));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_cur      <= '0;
      r_page     <= '0;
      r_step     <= '0;
      r_lifo     <= '0;
      r_cnt      <= '0;
      r_ram_rd   <= 1'b0;
      r_ram_addr <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_ram_rd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_cur      <= StartState;
            r_page     <= StartPage;
            r_step     <= '0;
            r_cnt      <= '0;
            r_ram_rd   <= 1'b1;
            r_ram_addr <= {StartPage, StartState[WD_STATE-1:WD_SEL]};
            r_state    <= S_READ;
          end
        end
        S_READ: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_cur  <= w_nxt;
          r_page <= w_page_dec;
          r_step <= r_step + WD_STEP'(1);
          // LIFO as a shift register: push enters at bit 0, bit 0 is the top.
          if (w_keep) begin
            r_lifo <= (r_lifo << 1) | DEC_LEN'(w_nxt[WD_STATE-1]);
            r_cnt  <= r_cnt + WD_CNT'(1);
          end
          if (w_last_step) begin
            r_valid <= 1'b1;
            r_state <= S_DRAIN;
          end else begin
            // Address for the next step is issued with the read strobe so
            // both are registered outputs during READ.
            r_ram_rd   <= 1'b1;
            r_ram_addr <= {w_page_dec, w_nxt[WD_STATE-1:WD_SEL]};
            r_state    <= S_READ;
          end
        end
        S_DRAIN: begin
          if (DataReady) begin
            r_lifo <= r_lifo >> 1;
            r_cnt  <= r_cnt - WD_CNT'(1);
            if (r_cnt == WD_CNT'(1)) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign RamRd     = r_ram_rd;
  assign RamAddr   = r_ram_addr;
  assign DataValid = r_valid;
  assign DataOut   = r_valid & r_lifo[0];
  assign DataLast  = r_valid & (r_cnt == WD_CNT'(1));
  assign Busy      = (r_state != S_IDLE);
  assign Done      = r_done;

endmodule

// File: tb/tb_tbu_param.sv
// tb/tb_tbu_param.sv - self-checking bench for tbu_param (small and default parameter sets)

module tb_tbu_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Small instance: WD_STATE=4, WD_WORD=4, WD_PAGE=3, TB_DEPTH=1, DEC_LEN=4
  logic       s_start, s_rd, s_out, s_valid, s_ready, s_last, s_busy, s_done;
  logic [3:0] s_state, s_rdata;
  logic [2:0] s_page;
  logic [4:0] s_addr;
  logic [3:0] ram_s [0:31];

  // Default instance: 8/8/6/63/16
  logic        d_start, d_rd, d_out, d_valid, d_ready, d_last, d_busy, d_done;
  logic [7:0]  d_state, d_rdata;
  logic [5:0]  d_page;
  logic [10:0] d_addr;
  logic [7:0]  ram_d [0:2047];

  tbu_param #(.WD_STATE(4), .WD_WORD(4), .WD_PAGE(3), .TB_DEPTH(1), .DEC_LEN(4)) u_small (
    .Clock(clk), .Reset(rst), .Start(s_start), .StartPage(s_page), .StartState(s_state),
    .RamRd(s_rd), .RamAddr(s_addr), .RamData(s_rdata), .DataOut(s_out), .DataValid(s_valid),
    .DataReady(s_ready), .DataLast(s_last), .Busy(s_busy), .Done(s_done));

  tbu_param u_dflt (
    .Clock(clk), .Reset(rst), .Start(d_start), .StartPage(d_page), .StartState(d_state),
    .RamRd(d_rd), .RamAddr(d_addr), .RamData(d_rdata), .DataOut(d_out), .DataValid(d_valid),
    .DataReady(d_ready), .DataLast(d_last), .Busy(d_busy), .Done(d_done));

  // Synchronous survivor RAMs
  always @(posedge clk) begin
    if (s_rd) s_rdata <= ram_s[s_addr];
    if (d_rd) d_rdata <= ram_d[d_addr];
  end

  int errors = 0;
  int checks = 0;

  int   exp_addr[$];
  logic exp_bits[$];
  int   obs_addr[$];
  logic obs_bits[$], obs_last[$];
  logic cv[$], cr[$], co[$], cl[$];
  int   first_valid, done_cycle, done_cnt;
  logic busy_c1;

  // Reference traceback written from the trellis rules with integer arithmetic.
  function automatic void build_model(input bit dflt, input int st, input int pg);
    int nst   = dflt ? 8 : 4;
    int nw    = dflt ? 8 : 4;
    int np    = dflt ? 6 : 3;
    int tb    = dflt ? 63 : 1;
    int dl    = dflt ? 16 : 4;
    int lsel  = dflt ? 3 : 2;
    int cur   = st;
    int page  = pg;
    int addr, word, b;
    exp_addr.delete();
    exp_bits.delete();
    for (int k = 0; k < tb + dl; k++) begin
      addr = page * (1 << (nst - lsel)) + cur / nw;
      exp_addr.push_back(addr);
      word = dflt ? int'(ram_d[addr]) : int'(ram_s[addr]);
      b    = (word >> (cur % nw)) & 1;
      cur  = (cur * 2 + b) % (1 << nst);
      // Newest decoded bit goes to the front so the list reads oldest-first.
      if (k >= tb) exp_bits.push_front(logic'(cur >> (nst - 1)));
      page = (page + (1 << np) - 1) % (1 << np);
    end
  endfunction

  // Drives one block on the small instance and records what it observes.
  // mode: 0 ready high, 1 stall 3 then toggle, 2 random ready.
  task automatic run_small(input int st, input int pg, input int mode, input bit glitch,
                           input bit chain, input int nst, input int npg,
                           input bit prestarted, input int budget);
    int dcnt = 0;
    obs_addr.delete(); obs_bits.delete(); obs_last.delete();
    cv.delete(); cr.delete(); co.delete(); cl.delete();
    first_valid = -1; done_cycle = -1; done_cnt = 0; busy_c1 = 1'b0;
    if (!prestarted) begin
      @(negedge clk);
      s_start = 1'b1; s_state = st[3:0]; s_page = pg[2:0];
    end
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      s_start = 1'b0;
      if (glitch && (c == 3 || c == 4)) begin
        s_start = 1'b1; s_state = st[3:0] ^ 4'hF; s_page = pg[2:0] ^ 3'h7;
      end
      if (c == 1) busy_c1 = s_busy;
      if (s_rd) obs_addr.push_back(int'(s_addr));
      if (s_valid) begin
        if (first_valid < 0) first_valid = c;
        if (glitch && dcnt == 0) begin
          s_start = 1'b1; s_state = st[3:0] ^ 4'h5;
        end
        case (mode)
          0:       s_ready = 1'b1;
          1:       s_ready = (dcnt < 3) ? 1'b0 : logic'(dcnt % 2);
          default: s_ready = logic'($urandom_range(0, 1));
        endcase
        dcnt++;
      end else begin
        s_ready = (mode == 0);
      end
      cv.push_back(s_valid); cr.push_back(s_ready); co.push_back(s_out); cl.push_back(s_last);
      if (s_valid && s_ready) begin
        obs_bits.push_back(s_out);
        obs_last.push_back(s_last);
      end
      if (s_done === 1'b1) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = c;
        if (chain) begin
          s_start = 1'b1; s_state = nst[3:0]; s_page = npg[2:0];
          return;
        end
      end
      if (done_cycle >= 0 && c >= done_cycle + 3) break;
    end
    s_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_start = 0; s_state = 0; s_page = 0; s_ready = 0;
    d_start = 0; d_state = 0; d_page = 0; d_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_rd, s_addr, s_out, s_valid, s_last, s_busy, s_done} !== 11'd0) begin
      errors++; $display("FAIL reset_small: got %b required 0", {s_rd, s_addr, s_out, s_valid, s_last, s_busy, s_done});
    end
    checks++;
    if ({d_rd, d_addr, d_out, d_valid, d_last, d_busy, d_done} !== 17'd0) begin
      errors++; $display("FAIL reset_dflt: got %b required 0", {d_rd, d_addr, d_out, d_valid, d_last, d_busy, d_done});
    end
    rst = 1'b0;
  endtask

  task automatic test_ram_const(input string nm, input logic [3:0] fill, input int st, input int pg);
    foreach (ram_s[i]) ram_s[i] = fill;
    build_model(0, st, pg);
    run_small(st, pg, 0, 0, 0, 0, 0, 0, 200);
    checks++;
    if (obs_addr.size() != exp_addr.size()) begin
      errors++; $display("FAIL %s addr_count: got %0d required %0d", nm, obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] != exp_addr[i]) begin
        errors++; $display("FAIL %s addr[%0d]: got %b required %b", nm, i, 5'(obs_addr[i]), 5'(exp_addr[i]));
      end
    end
    checks++;
    if (obs_bits.size() != 4) begin
      errors++; $display("FAIL %s bit_count: got %0d required 4", nm, obs_bits.size());
    end
    for (int i = 0; i < obs_bits.size() && i < 4; i++) begin
      checks++;
      if (obs_bits[i] !== exp_bits[i] || obs_last[i] !== (i == 3)) begin
        errors++; $display("FAIL %s bit[%0d]: got %b last %b required %b last %b", nm, i, obs_bits[i], obs_last[i], exp_bits[i], (i == 3));
      end
    end
    checks++;
    if (busy_c1 !== 1'b1 || first_valid != 11 || done_cycle != 15 || done_cnt != 1) begin
      errors++; $display("FAIL %s timing: busy1=%b first_valid=%0d done=%0d ndone=%0d required 1/11/15/1", nm, busy_c1, first_valid, done_cycle, done_cnt);
    end
  endtask

  task automatic test_backpressure(input string nm, input int mode, input bit glitch, input int iters);
    int st, pg;
    for (int it = 0; it < iters; it++) begin
      foreach (ram_s[i]) ram_s[i] = 4'($urandom);
      st = $urandom_range(0, 15); pg = $urandom_range(0, 7);
      build_model(0, st, pg);
      run_small(st, pg, mode, glitch, 0, 0, 0, 0, 300);
      checks++;
      if (obs_bits.size() != 4 || done_cnt != 1) begin
        errors++; $display("FAIL %s[%0d] count: bits=%0d dones=%0d required 4/1", nm, it, obs_bits.size(), done_cnt);
      end
      for (int i = 0; i < obs_bits.size() && i < 4; i++) begin
        checks++;
        if (obs_bits[i] !== exp_bits[i] || obs_last[i] !== (i == 3)) begin
          errors++; $display("FAIL %s[%0d] bit[%0d]: got %b last %b required %b last %b", nm, it, i, obs_bits[i], obs_last[i], exp_bits[i], (i == 3));
        end
      end
      for (int i = 1; i < cv.size(); i++) begin
        if (cv[i-1] === 1'b1 && cr[i-1] === 1'b0) begin
          checks++;
          if (cv[i] !== 1'b1 || co[i] !== co[i-1] || cl[i] !== cl[i-1]) begin
            errors++; $display("FAIL %s[%0d] hold@%0d: valid %b out %b last %b required 1 %b %b", nm, it, i + 1, cv[i], co[i], cl[i], co[i-1], cl[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int sta = $urandom_range(0, 15), pga = $urandom_range(0, 7);
    int stb = $urandom_range(0, 15), pgb = $urandom_range(0, 7);
    foreach (ram_s[i]) ram_s[i] = 4'($urandom);
    build_model(0, sta, pga);
    run_small(sta, pga, 0, 0, 1, stb, pgb, 0, 200);
    checks++;
    if (done_cycle != 15 || obs_bits.size() != 4) begin
      errors++; $display("FAIL b2b_first: done=%0d bits=%0d required 15/4", done_cycle, obs_bits.size());
    end
    for (int i = 0; i < obs_bits.size() && i < 4; i++) begin
      checks++;
      if (obs_bits[i] !== exp_bits[i]) begin
        errors++; $display("FAIL b2b_first bit[%0d]: got %b required %b", i, obs_bits[i], exp_bits[i]);
      end
    end
    build_model(0, stb, pgb);
    run_small(stb, pgb, 0, 0, 0, 0, 0, 1, 200);
    checks++;
    if (busy_c1 !== 1'b1 || obs_addr.size() == 0 || first_valid != 11 || done_cycle != 15) begin
      errors++; $display("FAIL b2b_second timing: busy1=%b reads=%0d first_valid=%0d done=%0d required 1/>0/11/15", busy_c1, obs_addr.size(), first_valid, done_cycle);
    end else begin
      checks++;
      if (obs_addr[0] != exp_addr[0]) begin
        errors++; $display("FAIL b2b_second addr0: got %0d required %0d", obs_addr[0], exp_addr[0]);
      end
    end
    for (int i = 0; i < obs_bits.size() && i < 4; i++) begin
      checks++;
      if (obs_bits[i] !== exp_bits[i]) begin
        errors++; $display("FAIL b2b_second bit[%0d]: got %b required %b", i, obs_bits[i], exp_bits[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int xfer = 0;
    int ndone = 0;
    bit reached = 0;
    foreach (ram_s[i]) ram_s[i] = 4'($urandom);
    @(negedge clk);
    s_start = 1'b1; s_state = 4'($urandom); s_page = 3'($urandom);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      s_start = 1'b0; s_ready = 1'b1;
      if (s_valid) xfer++;
      if (xfer == 2) begin reached = 1; break; end
    end
    checks++;
    if (!reached) begin
      errors++; $display("FAIL reset_mid reach: transfers=%0d required 2", xfer);
    end
    @(negedge clk);
    checks++;
    if (s_valid !== 1'b1 || s_last !== 1'b0) begin
      errors++; $display("FAIL reset_mid pending: valid %b last %b required 1 0", s_valid, s_last);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; s_ready = 1'b0;
    checks++;
    if ({s_rd, s_addr, s_out, s_valid, s_last, s_busy, s_done} !== 11'd0) begin
      errors++; $display("FAIL reset_mid outputs: got %b required 0", {s_rd, s_addr, s_out, s_valid, s_last, s_busy, s_done});
    end
    repeat (4) begin
      @(negedge clk);
      if (s_done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++; $display("FAIL reset_mid done: got %0d pulses required 0", ndone);
    end
    test_backpressure("after_reset", 0, 0, 1);
  endtask

  task automatic test_defaults(input int iters);
    int st, pg, fv, dc, c;
    logic ob[$], ol[$];
    for (int it = 0; it < iters; it++) begin
      foreach (ram_d[i]) ram_d[i] = 8'($urandom);
      st = $urandom_range(0, 255); pg = $urandom_range(0, 63);
      build_model(1, st, pg);
      ob.delete(); ol.delete(); fv = -1; dc = -1;
      @(negedge clk);
      d_start = 1'b1; d_state = st[7:0]; d_page = pg[5:0]; d_ready = 1'b1;
      for (c = 1; c <= 300; c++) begin
        @(negedge clk);
        d_start = 1'b0;
        if (d_valid) begin
          if (fv < 0) fv = c;
          ob.push_back(d_out); ol.push_back(d_last);
        end
        if (d_done === 1'b1) begin dc = c; break; end
      end
      d_ready = 1'b0;
      checks++;
      if (fv != 159 || dc != 175 || ob.size() != 16) begin
        errors++; $display("FAIL dflt[%0d] timing: first_valid=%0d done=%0d bits=%0d required 159/175/16", it, fv, dc, ob.size());
      end
      for (int i = 0; i < ob.size() && i < 16; i++) begin
        checks++;
        if (ob[i] !== exp_bits[i] || ol[i] !== (i == 15)) begin
          errors++; $display("FAIL dflt[%0d] bit[%0d]: got %b last %b required %b last %b", it, i, ob[i], ol[i], exp_bits[i], (i == 15));
        end
      end
    end
  endtask

  initial begin
    s_rdata = '0;
    d_rdata = '0;
    test_reset();
    test_ram_const("ram_zero", 4'h0, 15, 1);
    test_ram_const("ram_ones", 4'hF, 0, 1);
    test_backpressure("random_ready", 2, 0, 4);
    test_backpressure("backpressure", 1, 0, 3);
    test_backpressure("start_ignored", 1, 1, 3);
    test_back_to_back();
    test_reset_mid();
    test_defaults(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
